// File: rtl/pla_sop_sequencer_pkg.sv
// Shared types and default sizing for the sequential PLA sum-of-products evaluator.
package pla_seq_pkg;

  localparam int N_IN        = 15;
  localparam int N_CUBES_DEF = 16;
  localparam int HIT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  typedef struct packed {
    logic            en;
    logic [N_IN-1:0] care;
    logic [N_IN-1:0] val;
  } cube_t;

endpackage

// File: rtl/pla_sop_sequencer_if.sv
// Config, input-vector and result streams of pla_sop_sequencer; slave is the DUT side.
interface pla_sop_sequencer_if
  import pla_seq_pkg::*;
#(
  parameter int N_CUBES = N_CUBES_DEF,
  parameter int HIT_W   = HIT_W_DEF
);
  localparam int CW = $clog2(N_CUBES);

  logic            cfg_we;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_addr;
  logic            cfg_en;
  logic [N_IN-1:0] cfg_care;
  logic [N_IN-1:0] cfg_val;
  logic [CW:0]     cfg_num;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            out_valid;
  logic            out_ready;
  logic            out_y;
  logic [CW-1:0]   out_idx;
  logic [HIT_W-1:0] hit_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_en, cfg_care, cfg_val, cfg_num,
    output in_valid, in_vec, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y, out_idx, hit_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_en, cfg_care, cfg_val, cfg_num,
    input  in_valid, in_vec, out_ready,
    output cfg_ready, in_ready, out_valid, out_y, out_idx, hit_cnt
  );
endinterface

// File: rtl/pla_cube_match.sv
// Masked compare of one product term against an input vector; purely combinational.
module pla_cube_match
  import pla_seq_pkg::*;
(
  input  cube_t           cube,
  input  logic [N_IN-1:0] vec,
  output logic            hit
);
  assign hit = cube.en && (((vec ^ cube.val) & cube.care) == '0);
endmodule

// File: rtl/pla_sop_sequencer.sv
// Scans a programmable cube table one entry per cycle and reports the first hit.
module pla_sop_sequencer
  import pla_seq_pkg::*;
#(
  parameter int N_CUBES = N_CUBES_DEF,
  parameter int HIT_W   = HIT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pla_sop_sequencer_if.slave bus
);
  localparam int          CW      = $clog2(N_CUBES);
  localparam logic [CW:0] NUM_MAX = (CW+1)'(N_CUBES);

  state_e           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW:0]      num_q, num_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             y_q, y_d;
  logic [CW-1:0]    oidx_q, oidx_d;
  logic             ovalid_q, ovalid_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [N_CUBES-1:0] en_q, en_d;
  logic [N_IN-1:0]  care_q [N_CUBES];
  logic [N_IN-1:0]  val_q  [N_CUBES];

  logic  tbl_we;
  cube_t cur_cube;
  logic  cur_hit;

  assign tbl_we = bus.cfg_we && (state_q == IDLE);

  always_comb begin
    en_d = en_q;
    if (tbl_we) en_d[bus.cfg_addr] = bus.cfg_en;
  end

  always_comb cur_cube = '{en: en_q[idx_q], care: care_q[idx_q], val: val_q[idx_q]};

  pla_cube_match u_match (
    .cube (cur_cube),
    .vec  (vec_q),
    .hit  (cur_hit)
  );

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves one unassigned (no latch).
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    vec_d    = vec_q;
    y_d      = y_q;
    oidx_d   = oidx_q;
    ovalid_d = ovalid_q;
    hit_d    = hit_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        vec_d   = bus.in_vec;
        num_d   = (bus.cfg_num > NUM_MAX) ? NUM_MAX : bus.cfg_num;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (num_q == '0) begin
          y_d     = 1'b0;
          oidx_d  = '0;
          state_d = DONE;
        end else if (cur_hit) begin
          y_d     = 1'b1;
          oidx_d  = idx_q;
          state_d = DONE;
        end else if ({1'b0, idx_q} == num_q - (CW+1)'(1)) begin
          y_d     = 1'b0;
          oidx_d  = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      // First DONE cycle registers out_valid, giving the two-cycle minimum latency.
      DONE: begin
        if (!ovalid_q) begin
          ovalid_d = 1'b1;
        end else if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
          if (y_q && (hit_q != '1)) hit_d = hit_q + HIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      vec_q    <= '0;
      y_q      <= 1'b0;
      oidx_q   <= '0;
      ovalid_q <= 1'b0;
      hit_q    <= '0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      vec_q    <= vec_d;
      y_q      <= y_d;
      oidx_q   <= oidx_d;
      ovalid_q <= ovalid_d;
      hit_q    <= hit_d;
      en_q     <= en_d;
    end
  end

  // NOTE: care/val storage has no reset; a cleared en bit makes its contents irrelevant.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      care_q[bus.cfg_addr] <= bus.cfg_care;
      val_q[bus.cfg_addr]  <= bus.cfg_val;
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ovalid_q;
  assign bus.out_y     = y_q;
  assign bus.out_idx   = oidx_q;
  assign bus.hit_cnt   = hit_q;
endmodule

// File: tb/tb_pla_sop_sequencer.sv
// Randomized bench for pla_sop_sequencer against a flat first-hit reference model.
module tb_pla_sop_sequencer;
  import pla_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pla_sop_sequencer_if #(.N_CUBES(16), .HIT_W(16)) m ();
  pla_sop_sequencer_if #(.N_CUBES(16), .HIT_W(4))  s ();

  pla_sop_sequencer #(.N_CUBES(16), .HIT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  pla_sop_sequencer #(.N_CUBES(16), .HIT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(s.slave));

  int n_vec = 0;
  int n_err = 0;

  bit          m_en   [16];
  logic [14:0] m_care [16];
  logic [14:0] m_val  [16];
  int          m_hits = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: first enabled cube among the first min(num,16) whose cared bits equal the vector.
  function automatic void model_eval(input logic [14:0] vec, input int num,
                                     output logic y, output logic [3:0] idx, output int lat);
    int n;
    n   = (num > 16) ? 16 : num;
    y   = 1'b0;
    idx = 4'd0;
    lat = (n == 0) ? 2 : n + 1;
    for (int i = 0; i < n; i++) begin
      if (m_en[i] && (((vec ^ m_val[i]) & m_care[i]) == 15'd0)) begin
        y   = 1'b1;
        idx = 4'(i);
        lat = i + 2;
        break;
      end
    end
  endfunction

  task automatic cfg_write(input int a, input bit en, input logic [14:0] care, input logic [14:0] val);
    @(negedge clk);
    m.cfg_we = 1'b1; m.cfg_addr = 4'(a); m.cfg_en = en; m.cfg_care = care; m.cfg_val = val;
    @(posedge clk);
    @(negedge clk);
    m.cfg_we = 1'b0;
    m_en[a] = en; m_care[a] = care; m_val[a] = val;
  endtask

  // Apply one vector; optionally write a cube on the accept edge and stall out_ready for `hold` cycles.
  task automatic run_vec(input logic [14:0] vec, input logic [4:0] num, input int hold,
                         input bit wr, input int wa, input bit wen,
                         input logic [14:0] wc, input logic [14:0] wv);
    logic ey; logic [3:0] eidx; int elat; int lat;
    @(negedge clk);
    check("in_ready_idle", m.in_ready, 1);
    m.in_valid = 1'b1; m.in_vec = vec; m.cfg_num = num;
    if (wr) begin
      m.cfg_we = 1'b1; m.cfg_addr = 4'(wa); m.cfg_en = wen; m.cfg_care = wc; m.cfg_val = wv;
      m_en[wa] = wen; m_care[wa] = wc; m_val[wa] = wv;
    end
    model_eval(vec, int'(num), ey, eidx, elat);
    @(posedge clk);
    @(negedge clk);
    m.in_valid = 1'b0; m.cfg_we = 1'b0;
    lat = 0;
    while (!m.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", m.out_valid, 1);
    if (!m.out_valid) return;
    check("latency", lat, elat);
    check("out_y", m.out_y, ey);
    check("out_idx", m.out_idx, eidx);
    for (int h = 0; h < hold; h++) begin
      m.cfg_we = 1'b1; m.cfg_addr = eidx; m.cfg_en = 1'b0; m.cfg_care = 15'h0; m.cfg_val = 15'h0;
      @(posedge clk);
      @(negedge clk);
      m.cfg_we = 1'b0;
      check("hold_valid", m.out_valid, 1);
      check("hold_y", m.out_y, ey);
      check("hold_idx", m.out_idx, eidx);
      check("hold_in_ready", m.in_ready, 0);
      check("hold_cfg_ready", m.cfg_ready, 0);
    end
    m.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m.out_ready = 1'b0;
    if (ey && m_hits < 16'hFFFF) m_hits++;
    check("valid_drop", m.out_valid, 0);
    check("hit_cnt", m.hit_cnt, m_hits);
  endtask

  initial begin
    logic [14:0] v, c;
    int k, lat;
    bit seen;

    m.cfg_we = 0; m.cfg_addr = 0; m.cfg_en = 0; m.cfg_care = 0; m.cfg_val = 0; m.cfg_num = 0;
    m.in_valid = 0; m.in_vec = 0; m.out_ready = 0;
    s.cfg_we = 0; s.cfg_addr = 0; s.cfg_en = 0; s.cfg_care = 0; s.cfg_val = 0; s.cfg_num = 0;
    s.in_valid = 0; s.in_vec = 0; s.out_ready = 0;
    for (int i = 0; i < 16; i++) begin m_en[i] = 0; m_care[i] = 0; m_val[i] = 0; end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", m.in_ready, 1);
    check("rst_cfg_ready", m.cfg_ready, 1);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_out_y", m.out_y, 0);
    check("rst_out_idx", m.out_idx, 0);
    check("rst_hit_cnt", m.hit_cnt, 0);

    cfg_write(0, 1, 15'h7FFF, 15'h0040);
    run_vec(15'h0040, 5'd1, 0, 0, 0, 0, 0, 0);
    run_vec(15'h0041, 5'd1, 0, 0, 0, 0, 0, 0);

    cfg_write(0, 1, 15'h0001, 15'h0001);
    for (int i = 1; i <= 4; i++) cfg_write(i, 0, 15'h0, 15'h0);
    cfg_write(5, 1, 15'h0002, 15'h0002);
    run_vec(15'h0002, 5'd16, 0, 0, 0, 0, 0, 0);
    run_vec(15'h0000, 5'd16, 0, 0, 0, 0, 0, 0);
    run_vec(15'h0002, 5'd0,  0, 0, 0, 0, 0, 0);
    run_vec(15'h0000, 5'd20, 0, 0, 0, 0, 0, 0);

    run_vec(15'h0002, 5'd16, 5, 0, 0, 0, 0, 0);
    run_vec(15'h0002, 5'd16, 0, 0, 0, 0, 0, 0);

    // Write on the accept edge must be visible to that same scan.
    run_vec(15'h0100, 5'd16, 0, 1, 3, 1, 15'h0100, 15'h0100);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, 15), ($urandom_range(0, 3) != 0),
                  15'($urandom & $urandom & $urandom), 15'($urandom));
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = m_val[k] ^ (15'($urandom) & ~m_care[k]);
      else v = 15'($urandom);
      c = 15'($urandom & $urandom);
      run_vec(v, 5'($urandom_range(0, 20)), $urandom_range(0, 2),
              ($urandom_range(0, 4) == 0), $urandom_range(0, 15), 1'b1, c, 15'($urandom));
    end

    for (int i = 0; i < 16; i++) cfg_write(i, 0, 15'h7FFF, 15'h7FFF);
    cfg_write(10, 1, 15'h0, 15'h0);
    @(negedge clk);
    m.in_valid = 1'b1; m.in_vec = 15'h0; m.cfg_num = 5'd16;
    @(posedge clk);
    @(negedge clk);
    m.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_en[i] = 0;
    m_hits = 0;
    check("midrst_in_ready", m.in_ready, 1);
    check("midrst_cfg_ready", m.cfg_ready, 1);
    check("midrst_hit_cnt", m.hit_cnt, 0);
    check("midrst_out_y", m.out_y, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (m.out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);
    run_vec(15'h0000, 5'd16, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    s.cfg_we = 1'b1; s.cfg_addr = 4'd0; s.cfg_en = 1'b1; s.cfg_care = 15'h0; s.cfg_val = 15'h0;
    @(posedge clk);
    @(negedge clk);
    s.cfg_we = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      s.in_valid = 1'b1; s.in_vec = 15'($urandom); s.cfg_num = 5'd1;
      @(posedge clk);
      @(negedge clk);
      s.in_valid = 1'b0;
      lat = 0;
      while (!s.out_valid && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check("sat_valid", s.out_valid, 1);
      s.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s.out_ready = 1'b0;
      check("sat_hit_cnt", s.hit_cnt, (n > 15) ? 15 : n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
